// File: rtl/vc_test_sink.sv
`timescale 1ns/1ps
// ============================================================================
// vc_test_sink
// ----------------------------------------------------------------------------
// Receiving end of a unit-test bench stream. Accepts words on a val/rdy
// handshake, compares each accepted word in order against the expected-value
// memory `m` (loaded hierarchically by the bench), optionally throttles the
// sender with pseudo-random stalls, and reports mismatches plus a `done`
// flag once the expected stream has been fully consumed.
//
// Parameters
//   BIT_WIDTH     width of each checked word
//   RANDOM_DELAY  0: never stall; N>0: after each transfer stall 0..N-1 cycles
//   ENTRIES       depth of m (at most 1024)
//   LFSR_SEED     reset value of the stall LFSR (must be nonzero)
//
// Ports
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous, active-low reset
//   bits         in   incoming data word
//   val          in   incoming word valid
//   rdy          out  sink ready; a transfer happens when val && rdy at posedge
//   done         out  every expected word has been consumed
//   error_count  out  number of mismatching transfers, saturates at 16'hFFFF
//   fail         out  sticky, at least one mismatch seen
//   fail_index   out  stream index of the first mismatch
//   fail_got     out  received word of the first mismatch
//   fail_exp     out  expected word of the first mismatch
//
// End of stream is either index == ENTRIES or an all-X entry in m. Expected
// bits that are X or Z are don't-care; every other bit must match exactly,
// so an X/Z received where 0/1 is expected is a mismatch.
// ============================================================================
module vc_test_sink #(
    parameter int unsigned BIT_WIDTH    = 1,
    parameter int unsigned RANDOM_DELAY = 0,
    parameter int unsigned ENTRIES      = 1024,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2345
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] bits,
    input  logic                 val,
    output logic                 rdy,
    output logic                 done,
    output logic [15:0]          error_count,
    output logic                 fail,
    output logic [9:0]           fail_index,
    output logic [BIT_WIDTH-1:0] fail_got,
    output logic [BIT_WIDTH-1:0] fail_exp
);

    // Address width of m; a one-entry memory still needs a one-bit address.
    localparam int unsigned ADDR_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    // The running index needs one extra bit so that ENTRIES == 1024 can be
    // represented as the end-of-stream position without wrapping to 0.
    localparam logic [10:0] END_INDEX = 11'(ENTRIES);
    // Divisor for the stall draw; forced to 1 when stalls are disabled so the
    // modulo below is always well defined.
    localparam logic [31:0] DELAY_MOD = (RANDOM_DELAY > 0) ? 32'(RANDOM_DELAY) : 32'd1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Expected-value memory. Only the bench writes it; reset leaves it alone
    // so a restarted stream is checked against the same contents.
    logic [BIT_WIDTH-1:0] m [ENTRIES];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [10:0]          index_q,       index_d;
    logic [31:0]          delay_q,       delay_d;
    logic [31:0]          lfsr_q,        lfsr_d;
    logic [15:0]          error_count_q, error_count_d;
    logic                 fail_q,        fail_d;
    logic [9:0]           fail_index_q,  fail_index_d;
    logic [BIT_WIDTH-1:0] fail_got_q,    fail_got_d;
    logic [BIT_WIDTH-1:0] fail_exp_q,    fail_exp_d;

    // ------------------------------------------------------------------------
    // Expected word lookup and per-bit comparison
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]    rd_addr;
    logic [BIT_WIDTH-1:0] exp_word;
    logic [BIT_WIDTH-1:0] exp_unknown;   // expected bit is X or Z
    logic [BIT_WIDTH-1:0] bit_mismatch;  // cared-about bit differs
    logic                 at_end;
    logic                 xfer;
    logic                 mismatch;
    logic [31:0]          lfsr_step;

    assign rd_addr  = index_q[ADDR_W-1:0];
    assign exp_word = m[rd_addr];

    // A bit that is neither a definite 0 nor a definite 1 is X or Z. The
    // case-inequality keeps an X/Z on `bits` from masking a real mismatch.
    for (genvar gi = 0; gi < BIT_WIDTH; gi++) begin : g_bit_cmp
        assign exp_unknown[gi]  = (exp_word[gi] !== 1'b0) && (exp_word[gi] !== 1'b1);
        assign bit_mismatch[gi] = !exp_unknown[gi] && (bits[gi] !== exp_word[gi]);
    end

    // The index test comes first: past the last entry the memory read is
    // out of range and must not be relied on.
    assign at_end   = (index_q == END_INDEX) || (&exp_unknown);
    assign mismatch = |bit_mismatch;

    // rdy depends on state and reset only, never on val.
    assign rdy  = reset && !at_end && (delay_q == 32'd0);
    assign done = reset && at_end;
    assign xfer = val && rdy;

    // Galois LFSR, shifting right, feedback applied when the dropped bit is 1.
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        index_d       = index_q;
        delay_d       = delay_q;
        lfsr_d        = lfsr_step;
        error_count_d = error_count_q;
        fail_d        = fail_q;
        fail_index_d  = fail_index_q;
        fail_got_d    = fail_got_q;
        fail_exp_d    = fail_exp_q;

        // Count down an active stall. A transfer cannot coincide with a
        // nonzero delay, but its load is placed last so it would win anyway.
        if (delay_q != 32'd0) begin
            delay_d = delay_q - 32'd1;
        end

        if (xfer) begin
            index_d = index_q + 11'd1;

            if (RANDOM_DELAY > 0) begin
                delay_d = lfsr_q % DELAY_MOD;
            end

            if (mismatch) begin
                if (error_count_q != 16'hFFFF) begin
                    error_count_d = error_count_q + 16'd1;
                end
                // Only the first mismatch is captured; later ones just count.
                if (!fail_q) begin
                    fail_d       = 1'b1;
                    fail_index_d = index_q[9:0];
                    fail_got_d   = bits;
                    fail_exp_d   = exp_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            index_q       <= '0;
            delay_q       <= '0;
            lfsr_q        <= LFSR_SEED;
            error_count_q <= '0;
            fail_q        <= 1'b0;
            fail_index_q  <= '0;
            fail_got_q    <= '0;
            fail_exp_q    <= '0;
        end else begin
            index_q       <= index_d;
            delay_q       <= delay_d;
            lfsr_q        <= lfsr_d;
            error_count_q <= error_count_d;
            fail_q        <= fail_d;
            fail_index_q  <= fail_index_d;
            fail_got_q    <= fail_got_d;
            fail_exp_q    <= fail_exp_d;
        end
    end

    assign error_count = error_count_q;
    assign fail        = fail_q;
    assign fail_index  = fail_index_q;
    assign fail_got    = fail_got_q;
    assign fail_exp    = fail_exp_q;

endmodule
